// File: rtl/prio_encoder.sv
// Registered priority encoder: reduces an m-bit request vector to the n-bit index
// of its highest set bit, with a valid flag. One cycle of latency, hold on en = 0.
module prio_encoder #(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [m-1:0] in,
  output logic [n-1:0] out,
  output logic         valid
);

  // Reject configurations whose index field cannot name every request bit.
  generate
    if (m < 2) begin : g_bad_m
      $fatal(1, "prio_encoder: m must be at least 2 (m=%0d)", m);
    end
    if (n < $clog2(m)) begin : g_bad_n
      $fatal(1, "prio_encoder: n=%0d too narrow for m=%0d", n, m);
    end
  endgenerate

  logic [n-1:0] idx;
  logic         any;
  logic [n-1:0] out_reg;
  logic         valid_reg;

  // Ascending scan with later hits overriding earlier ones, so the highest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < m; i++) begin
      if (in[i]) begin
        idx = n'(i);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      out_reg   <= idx;
      valid_reg <= any;
    end
  end

  assign out   = out_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_prio_encoder.sv
// Directed-vector bench for prio_encoder: a default 4-bit instance and a wide 8-bit
// instance, each vector checked one cycle after it is applied.
module tb_prio_encoder;

  logic       clk;
  logic       rst4, en4;
  logic [3:0] in4;
  logic [1:0] out4;
  logic       valid4;
  logic       rst8, en8;
  logic [7:0] in8;
  logic [2:0] out8;
  logic       valid8;

  int vectors;
  int miscompares;

  prio_encoder #(.m(4), .n(2)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .in(in4), .out(out4), .valid(valid4)
  );

  prio_encoder #(.m(8), .n(3)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .in(in8), .out(out8), .valid(valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst4 = 1'b1; en4 = 1'b1; in4 = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out4 !== 2'd0 || valid4 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: out=%0d valid=%b, want out=0 valid=0", c, out4, valid4);
      end else $display("reset_hold[%0d]: out=%0d valid=%b", c, out4, valid4);
    end
    rst4 = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd3 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: out=%0d valid=%b, want out=3 valid=1", out4, valid4);
    end else $display("reset_release: out=%0d valid=%b", out4, valid4);
  endtask

  task automatic test_one_hot();
    logic [3:0] vin [4];
    logic [1:0] vout [4];
    vin  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    vout = '{2'd0, 2'd1, 2'd2, 2'd3};
    en4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in4 = vin[k];
      @(posedge clk); #1;
      vectors++;
      if (out4 !== vout[k] || valid4 !== 1'b1) begin
        miscompares++;
        $display("FAIL one_hot in=%b: out=%0d valid=%b, want out=%0d valid=1", vin[k], out4, valid4, vout[k]);
      end else $display("one_hot in=%b: out=%0d valid=%b", vin[k], out4, valid4);
    end
  endtask

  task automatic test_multi_hot();
    logic [3:0] vin [4];
    logic [1:0] vout [4];
    vin  = '{4'b0011, 4'b0110, 4'b1111, 4'b1001};
    vout = '{2'd1, 2'd2, 2'd3, 2'd3};
    en4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in4 = vin[k];
      @(posedge clk); #1;
      vectors++;
      if (out4 !== vout[k] || valid4 !== 1'b1) begin
        miscompares++;
        $display("FAIL multi_hot in=%b: out=%0d valid=%b, want out=%0d valid=1", vin[k], out4, valid4, vout[k]);
      end else $display("multi_hot in=%b: out=%0d valid=%b", vin[k], out4, valid4);
    end
  endtask

  task automatic test_zero();
    en4 = 1'b1;
    in4 = 4'b0000;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd0 || valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_input: out=%0d valid=%b, want out=0 valid=0", out4, valid4);
    end else $display("zero_input: out=%0d valid=%b", out4, valid4);
    in4 = 4'b0001;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd0 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_then_bit0: out=%0d valid=%b, want out=0 valid=1", out4, valid4);
    end else $display("zero_then_bit0: out=%0d valid=%b", out4, valid4);
  endtask

  task automatic test_enable_hold();
    logic [3:0] vin [3];
    vin = '{4'b1000, 4'b0001, 4'b0000};
    en4 = 1'b1;
    in4 = 4'b0100;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd2 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_capture: out=%0d valid=%b, want out=2 valid=1", out4, valid4);
    end else $display("hold_capture: out=%0d valid=%b", out4, valid4);
    // Outputs must not follow in between edges.
    in4 = 4'b1000;
    #2;
    vectors++;
    if (out4 !== 2'd2 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL no_comb_path: out=%0d valid=%b, want out=2 valid=1", out4, valid4);
    end else $display("no_comb_path: out=%0d valid=%b", out4, valid4);
    en4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in4 = vin[k];
      @(posedge clk); #1;
      vectors++;
      if (out4 !== 2'd2 || valid4 !== 1'b1) begin
        miscompares++;
        $display("FAIL hold in=%b: out=%0d valid=%b, want out=2 valid=1", vin[k], out4, valid4);
      end else $display("hold in=%b: out=%0d valid=%b", vin[k], out4, valid4);
    end
    en4 = 1'b1;
    in4 = 4'b0001;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd0 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: out=%0d valid=%b, want out=0 valid=1", out4, valid4);
    end else $display("hold_release: out=%0d valid=%b", out4, valid4);
  endtask

  task automatic test_back_to_back_reset();
    en4 = 1'b1;
    rst4 = 1'b1;
    in4 = 4'b1000;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd0 || valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL midstream_reset: out=%0d valid=%b, want out=0 valid=0", out4, valid4);
    end else $display("midstream_reset: out=%0d valid=%b", out4, valid4);
    rst4 = 1'b0;
    in4 = 4'b0010;
    @(posedge clk); #1;
    vectors++;
    if (out4 !== 2'd1 || valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset: out=%0d valid=%b, want out=1 valid=1", out4, valid4);
    end else $display("after_reset: out=%0d valid=%b", out4, valid4);
  endtask

  task automatic test_wide();
    logic [7:0] vin [5];
    logic [2:0] vout [5];
    logic       vval [5];
    logic       vrst [5];
    vin  = '{8'b0000_0000, 8'b1000_0000, 8'b0001_0100, 8'b0100_0000, 8'b0100_0000};
    vrst = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vout = '{3'd0, 3'd7, 3'd4, 3'd0, 3'd6};
    vval = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    en8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rst8 = vrst[k];
      in8  = vin[k];
      @(posedge clk); #1;
      vectors++;
      if (out8 !== vout[k] || valid8 !== vval[k]) begin
        miscompares++;
        $display("FAIL wide rst=%b in=%b: out=%0d valid=%b, want out=%0d valid=%b",
                 vrst[k], vin[k], out8, valid8, vout[k], vval[k]);
      end else $display("wide rst=%b in=%b: out=%0d valid=%b", vrst[k], vin[k], out8, valid8);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst4 = 1'b0; en4 = 1'b0; in4 = '0;
    rst8 = 1'b0; en8 = 1'b0; in8 = '0;
    @(posedge clk); #1;
    test_reset();
    test_one_hot();
    test_multi_hot();
    test_zero();
    test_enable_hold();
    test_back_to_back_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
